lattice_scan_sequencer: RTL
===========================

// Module: lattice_scan_sequencer
// PURPOSE
//  Generates the principal (hor,vert) raster sweep, L-R then T-B, that drives the
//  principal-to-direction address mapper for one lattice streaming/collision pass.
//  Issues one coordinate per accepted beat under valid/ready.
//  Tracks each accepted coordinate through a fixed BRAM read latency and presents
//  it again as a write-back strobe. Signals done once the last write-back retires.
// PARAMETERS
//  HPIXELS     64  lattice width; HOR_SIZE  = $clog2(HPIXELS)
//  VPIXELS     48  lattice height; VERT_SIZE = $clog2(VPIXELS)
//  RW_LATENCY  3   cycles from accepted coordinate to write-back strobe (>=1)
// PORTS
//  clk_in        in   1          system clock
//  rst_n_in      in   1          asynchronous reset, active-low
//  start_in      in   1          request one sweep; sampled only in IDLE
//  ready_in      in   1          downstream accepts hor_out/vert_out this cycle
//  hor_out       out  HOR_SIZE   principal column
//  vert_out      out  VERT_SIZE  principal row
//  valid_out     out  1          hor_out/vert_out valid
//  last_out      out  1          current beat is (HPIXELS-1,VPIXELS-1)
//  wb_valid_out  out  1          write-back strobe, RW_LATENCY cycles after acceptance
//  wb_hor_out    out  HOR_SIZE   column of retiring beat
//  wb_vert_out   out  VERT_SIZE  row of retiring beat
//  busy_out      out  1          high in SCAN, DRAIN and DONE
//  done_out      out  1          one-cycle pulse, sweep fully retired
//  sweep_cnt_out out  16         completed sweeps, wraps 16'hFFFF->0
// BEHAVIOUR
//  - Reset: async on rst_n_in low. State=IDLE. All outputs 0. Pipeline valids cleared.
//    Reset mid-sweep abandons the sweep; no done_out is produced.
//  - Accept = valid_out & ready_in. hor/vert advance only on accept. Outputs are held
//    stable while valid_out & !ready_in.
//  - Advance: hor==HPIXELS-1 -> hor=0 and vert+1; otherwise hor+1. Compare against
//    HPIXELS-1/VPIXELS-1, never power-of-two wrap.
//  - last_out = valid_out & hor==HPIXELS-1 & vert==VPIXELS-1 (combinational).
//  - FSM:
//    - IDLE: start_in -> SCAN with hor=vert=0. valid_out rises the next cycle.
//    - SCAN: valid_out=1. Accept with last_out -> DRAIN; valid_out drops the next cycle.
//    - DRAIN: valid_out=0. Stays until the write-back pipeline holds no valid entry.
//      That condition is reached RW_LATENCY cycles after the last accept -> DONE.
//    - DONE: done_out=1 for exactly 1 cycle. sweep_cnt_out increments. -> IDLE.
//  - start_in outside IDLE is ignored; it is not queued.
//  - Write-back pipeline: RW_LATENCY-deep shift of {accept,hor,vert}. Shifts every
//    cycle regardless of ready_in, so stalls become bubbles (wb_valid_out=0).
//    Exactly HPIXELS*VPIXELS wb strobes per sweep, in issue order.
//  - First-beat latency: start_in at edge N -> valid_out high after edge N+1.
// CONFIGURATION
//  SCAN_AUTO_RESTART_EN defined:
//    - DONE -> SCAN directly, with hor=vert=0. start_in is not needed.
//    - busy_out stays 1 after the first start. done_out and sweep_cnt_out still
//      pulse/count per sweep. Only reset returns the block to IDLE.
//  SCAN_AUTO_RESTART_EN undefined: DONE -> IDLE as above.
// TESTING  (HPIXELS=4, VPIXELS=3, RW_LATENCY=3 unless stated)
//  - Reset mid-SCAN at (2,1) -> all outputs 0 same cycle. No done_out.
//    Next start_in restarts at (0,0).
//  - start_in pulse, ready_in=1 -> 12 consecutive beats (0,0),(1,0)..(3,2).
//    last_out only on (3,2). wb strobes match, 3 cycles later.
//    done_out 1 cycle after final wb. sweep_cnt_out=1.
//  - ready_in low 2 cycles at (3,0) -> hor/vert held at (3,0). 2 wb bubbles.
//    Next accept is (0,1). Total wb strobes = 12.
//  - start_in held high through a whole sweep -> one sweep only; IDLE reached.
//    A further start_in pulse gives sweep_cnt_out=2.
//  - RW_LATENCY=1, ready_in=1 -> wb_valid_out trails valid_out by 1 cycle.
//    DRAIN lasts 1 cycle.
//  - SCAN_AUTO_RESTART_EN, 3 sweeps -> (0,0) reissued the cycle after DONE.
//    done_out pulses 3 times. sweep_cnt_out=3. busy_out never drops.

Source files
------------

// File: rtl/lattice_scan_sequencer.sv
// lattice_scan_sequencer: raster (hor,vert) sweep with valid/ready issue and latency-matched write-back strobe; SCAN_AUTO_RESTART_EN loops sweeps forever
module lattice_scan_sequencer #(
  parameter int HPIXELS = 64,
  parameter int VPIXELS = 48,
  parameter int RW_LATENCY = 3,
  localparam int HOR_SIZE = $clog2(HPIXELS),
  localparam int VERT_SIZE = $clog2(VPIXELS)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  input  logic                 ready_in,
  output logic [HOR_SIZE-1:0]  hor_out,
  output logic [VERT_SIZE-1:0] vert_out,
  output logic                 valid_out,
  output logic                 last_out,
  output logic                 wb_valid_out,
  output logic [HOR_SIZE-1:0]  wb_hor_out,
  output logic [VERT_SIZE-1:0] wb_vert_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [15:0]          sweep_cnt_out
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic                 v;
    logic [HOR_SIZE-1:0]  h;
    logic [VERT_SIZE-1:0] vt;
  } wb_t;
`ifdef SCAN_AUTO_RESTART_EN
  localparam state_t AFTER_DONE = SCAN;
`else
  localparam state_t AFTER_DONE = IDLE;
`endif
  state_t state, state_nx;
  logic [HOR_SIZE-1:0] hor;
  logic [VERT_SIZE-1:0] vert;
  logic acc, h_end, v_end, drained;
  wb_t head;
  wb_t [RW_LATENCY-1:0] pipe;
  wb_t [RW_LATENCY:0] ext;
  assign h_end = hor == HOR_SIZE'(HPIXELS - 1);
  assign v_end = vert == VERT_SIZE'(VPIXELS - 1);
  assign valid_out = state == SCAN;
  assign last_out = valid_out & h_end & v_end;
  assign acc = valid_out & ready_in;
  assign hor_out = hor;
  assign vert_out = vert;
  assign busy_out = state != IDLE;
  assign done_out = state == DONE;
  assign head = '{v: acc, h: hor, vt: vert};
  assign ext = {pipe, head};
  assign wb_valid_out = pipe[RW_LATENCY-1].v;
  assign wb_hor_out = pipe[RW_LATENCY-1].h;
  assign wb_vert_out = pipe[RW_LATENCY-1].vt;
  // the tail entry retires on the coming edge, so only the earlier stages hold DRAIN open
  always_comb begin
    drained = 1'b1;
    for (int i = 0; i < RW_LATENCY - 1; i++) drained = drained & ~pipe[i].v;
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (start_in ? SCAN : IDLE) :
               state == SCAN  ? (acc && last_out ? DRAIN : SCAN) :
               state == DRAIN ? (drained ? DONE : DRAIN) : AFTER_DONE;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      hor <= '0;
      vert <= '0;
      sweep_cnt_out <= '0;
      pipe <= '0;
    end else begin
      state <= state_nx;
      pipe <= ext[RW_LATENCY-1:0];
      if (state == DONE) sweep_cnt_out <= sweep_cnt_out + 1'b1;
      if (acc) begin
        hor <= h_end ? '0 : hor + 1'b1;
        vert <= last_out ? '0 : h_end ? vert + 1'b1 : vert;
      end else if (state == IDLE) begin
        hor <= '0;
        vert <= '0;
      end
    end
  end
endmodule
